// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state type for the divider
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int CNT_W      = 6;
    localparam int ITERATIONS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // One extra bit so the borrow of the trial subtraction is visible.
    assign shifted = {rem_i, dvd_bit_i};
    assign diff    = shifted - {1'b0, dsr_i};

    always_comb begin
        q_bit_o = ~diff[WIDTH];
        rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - 32-iteration restoring divider, signed/unsigned, registered results
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             div_clk,
    input  logic             resetn,
    input  logic             div,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             complete
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] x_raw_q, x_raw_d;
    logic             x_neg_q, x_neg_d;
    logic             y_neg_q, y_neg_d;
    logic             sgn_q, sgn_d;
    logic             yzero_q, yzero_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_final;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i    (rem_q),
        .dvd_bit_i(dvd_q[WIDTH-1]),
        .dsr_i    (dsr_q),
        .rem_o    (step_rem),
        .q_bit_o  (step_q)
    );

    assign q_final = {quo_q[WIDTH-2:0], step_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        x_raw_d = x_raw_q;
        x_neg_d = x_neg_q;
        y_neg_d = y_neg_q;
        sgn_d   = sgn_q;
        yzero_d = yzero_q;
        s_d     = s_q;
        r_d     = r_q;

        case (state_q)
            IDLE: begin
                if (div) begin
                    // Magnitudes feed the unsigned core; signs are re-applied at the end.
                    x_neg_d = div_signed & x[WIDTH-1];
                    y_neg_d = div_signed & y[WIDTH-1];
                    dvd_d   = (div_signed & x[WIDTH-1]) ? -x : x;
                    dsr_d   = (div_signed & y[WIDTH-1]) ? -y : y;
                    sgn_d   = div_signed;
                    yzero_d = (y == '0);
                    x_raw_d = x;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = q_final;
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
                    if (yzero_q) begin
                        s_d = '1;
                        r_d = x_raw_q;
                    end else begin
                        s_d = (sgn_q && (x_neg_q ^ y_neg_q)) ? -q_final : q_final;
                        r_d = (sgn_q && x_neg_q) ? -step_rem : step_rem;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge div_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            x_raw_q <= '0;
            x_neg_q <= 1'b0;
            y_neg_q <= 1'b0;
            sgn_q   <= 1'b0;
            yzero_q <= 1'b0;
            s_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            x_raw_q <= x_raw_d;
            x_neg_q <= x_neg_d;
            y_neg_q <= y_neg_d;
            sgn_q   <= sgn_d;
            yzero_q <= yzero_d;
            s_q     <= s_d;
            r_q     <= r_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = (state_q == CALC);
    assign complete = (state_q == DONE);

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - self-checking bench for divider against an arithmetic reference
module tb_divider;

    logic        div_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic [31:0] s;
    logic [31:0] r;
    logic        busy;
    logic        complete;

    int total = 0;
    int bad = 0;

    divider #(.WIDTH(32)) dut (
        .div_clk   (div_clk),
        .resetn    (resetn),
        .div       (div),
        .div_signed(div_signed),
        .x         (x),
        .y         (y),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .complete  (complete)
    );

    always #5 div_clk = ~div_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [31:0] es;
        logic [31:0] er;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Truncating division computed in 64-bit integer arithmetic.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
        longint sa, sb, q, rm;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        rm = sa % sb;
        return {q[31:0], rm[31:0]};
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         output logic [31:0] qs, output logic [31:0] qr, output int lat);
        @(negedge div_clk);
        x = a; y = b; div_signed = sg; div = 1'b1;
        @(posedge div_clk);
        #1;
        div = 1'b0;
        x = $urandom; y = $urandom; div_signed = ~sg;
        lat = 0;
        while (1) begin
            @(posedge div_clk);
            lat++;
            @(negedge div_clk);
            if (complete) break;
            if (lat > 100) break;
        end
        qs = s;
        qr = r;
    endtask

    vec_t        vt[12];
    logic [31:0] gs, gr;
    int          lat;
    int          ncomp;
    logic [63:0] e;

    logic [31:0] qx[$];
    logic [31:0] qy[$];
    logic        qsg[$];
    logic [31:0] drv_x, drv_y;
    logic        drv_sg;
    logic        prev_busy;
    int          last_rise;
    int          nres;
    int          nacc;

    initial begin
        vt[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2};
        vt[1]  = '{32'hFFFFFF9C,  32'd7,         1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE};
        vt[2]  = '{32'd100,       32'hFFFFFFF9,  1'b1, 32'hFFFFFFF2,  32'd2};
        vt[3]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0};
        vt[4]  = '{32'h12345678,  32'd0,         1'b0, 32'hFFFFFFFF,  32'h12345678};
        vt[5]  = '{32'h12345678,  32'd0,         1'b1, 32'hFFFFFFFF,  32'h12345678};
        vt[6]  = '{32'h80000001,  32'd0,         1'b1, 32'hFFFFFFFF,  32'h80000001};
        vt[7]  = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000};
        vt[8]  = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0};
        vt[9]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, 32'd3,         32'hFFFFFFFF};
        vt[10] = '{32'd5,         32'd10,        1'b0, 32'd0,         32'd5};
        vt[11] = '{32'hFFFFFFFF,  32'd10,        1'b0, 32'h19999999,  32'd5};

        repeat (3) @(posedge div_clk);
        @(negedge div_clk);
        chk("reset_s", {32'd0, s}, 64'd0);
        chk("reset_r", {32'd0, r}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_complete", {63'd0, complete}, 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(vt[i].a, vt[i].b, vt[i].sg, gs, gr, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
            chk($sformatf("vec%0d_sr", i), {gs, gr}, {vt[i].es, vt[i].er});
        end

        // Results hold while the next operation runs.
        do_op(32'd100, 32'd7, 1'b0, gs, gr, lat);
        @(negedge div_clk);
        x = 32'd1000; y = 32'd3; div_signed = 1'b0; div = 1'b1;
        @(posedge div_clk);
        #1;
        div = 1'b0;
        chk("accept_busy", {63'd0, busy}, 64'd1);
        repeat (5) @(posedge div_clk);
        @(negedge div_clk);
        chk("hold_sr", {s, r}, {32'd14, 32'd2});
        chk("busy_no_complete", {62'd0, busy, complete}, {62'd0, 2'b10});
        lat = 0;
        while (!complete && lat < 100) begin
            @(negedge div_clk);
            lat++;
        end
        chk("hold_next_sr", {s, r}, {32'd333, 32'd1});

        // Reset in the middle of an operation.
        @(negedge div_clk);
        x = 32'hFFFF0000; y = 32'd3; div_signed = 1'b0; div = 1'b1;
        @(posedge div_clk);
        #1;
        div = 1'b0;
        repeat (10) @(posedge div_clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("abort_sr", {s, r}, 64'd0);
        chk("abort_flags", {62'd0, busy, complete}, 64'd0);
        repeat (3) @(negedge div_clk);
        resetn = 1'b1;
        ncomp = 0;
        repeat (40) begin
            @(negedge div_clk);
            if (complete) ncomp++;
        end
        chk("abort_no_complete", 64'(ncomp), 64'd0);
        do_op(32'd96, 32'd8, 1'b0, gs, gr, lat);
        chk("after_reset_sr", {gs, gr}, {32'd12, 32'd0});
        chk("after_reset_latency", 64'(lat), 64'd32);

        // div held high with operands changing every cycle.
        prev_busy = 1'b0;
        last_rise = -1;
        nres = 0;
        nacc = 0;
        drv_x = '0; drv_y = '0; drv_sg = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge div_clk);
            if (busy && complete) chk("busy_and_complete", 64'd1, 64'd0);
            if (busy && !prev_busy) begin
                qx.push_back(drv_x);
                qy.push_back(drv_y);
                qsg.push_back(drv_sg);
                if (last_rise >= 0) chk("b2b_period", 64'(c - last_rise), 64'd34);
                last_rise = c;
                nacc++;
            end
            if (complete) begin
                if (qx.size() == 0) begin
                    chk("complete_without_accept", 64'd1, 64'd0);
                end else begin
                    e = ref_div(qx[0], qy[0], qsg[0]);
                    chk($sformatf("b2b_sr x=%h y=%h sg=%0d", qx[0], qy[0], qsg[0]), {s, r}, e);
                    void'(qx.pop_front());
                    void'(qy.pop_front());
                    void'(qsg.pop_front());
                    nres++;
                end
            end
            prev_busy = busy;
            drv_x = $urandom;
            drv_y = $urandom >> $urandom_range(0, 31);
            drv_sg = 1'($urandom_range(0, 1));
            x = drv_x; y = drv_y; div_signed = drv_sg; div = 1'b1;
        end
        div = 1'b0;
        lat = 0;
        while (qx.size() != 0 && lat < 100) begin
            @(negedge div_clk);
            lat++;
            if (complete) begin
                e = ref_div(qx[0], qy[0], qsg[0]);
                chk("b2b_tail_sr", {s, r}, e);
                void'(qx.pop_front());
                void'(qy.pop_front());
                void'(qsg.pop_front());
                nres++;
            end
        end
        chk("b2b_results_eq_accepts", 64'(nres), 64'(nacc));
        chk("b2b_enough_results", 64'(nres >= 8), 64'd1);

        // Random operands against the reference model.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, b;
            logic        sg;
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom >> $urandom_range(0, 31);
                2:       b = -($urandom >> $urandom_range(0, 31));
                default: b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 9));
            endcase
            sg = 1'($urandom_range(0, 1));
            do_op(a, b, sg, gs, gr, lat);
            if (lat != 32) chk("rand_latency", 64'(lat), 64'd32);
            chk($sformatf("rand x=%h y=%h sg=%0d", a, b, sg), {gs, gr}, ref_div(a, b, sg));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
